// File: rtl/julia_pkg.sv
// Shared types and constants for the julia pixel writer.
// Imported by the writer FSM and its frame counter.
package julia_pkg;

   localparam int NUM_JULIA_DEF    = 16;
   localparam int FRAME_PIXELS_DEF = 307200;
   localparam int ACK_TIMEOUT_DEF  = 255;

   localparam logic [3:0] BYTE_EN_ALL = 4'hF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      ACK      = 2'd2,
      WAIT_CLR = 2'd3
   } wr_state_e;

endpackage

// File: rtl/pixel_frame_counter.sv
// Pixels-per-frame counter: wraps at FRAME_PIXELS and
// pulses done on the completing write; clear wins.
module pixel_frame_counter
   import julia_pkg::*;
#(
   parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
   parameter int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o,
   output logic             done_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIXELS - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q, done_d;

   // next count: clear beats increment, last pixel wraps to 0
   always_comb begin
      count_d = count_q;
      done_d  = 1'b0;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         if (count_q == LAST) begin
            count_d = '0;
            done_d  = 1'b1;
         end else begin
            count_d = count_q + ONE;
         end
      end
   end

   // count and done registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign count_o = count_q;
   assign done_o  = done_q;

endmodule

// File: rtl/julia_pixel_writer.sv
// Drains the worker search: one Avalon write per found
// pixel, then a free pulse back to the selected worker.
module julia_pixel_writer
   import julia_pkg::*;
#(
   parameter int NUM_JULIA    = NUM_JULIA_DEF,
   parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
   parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
   parameter int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 found,
   input  logic [31:0]          sel_address,
   input  logic [31:0]          sel_data,
   input  logic [NUM_JULIA-1:0] mask,
   output logic [NUM_JULIA-1:0] free,
   output logic [31:0]          avm_address,
   output logic                 avm_write,
   output logic [31:0]          avm_writedata,
   output logic [3:0]           avm_byteenable,
   input  logic                 avm_waitrequest,
   input  logic                 frame_clear,
   output logic [CNT_W-1:0]     pixel_count,
   output logic                 frame_done,
   output logic                 ack_error,
   output logic                 busy
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
   localparam logic [NUM_JULIA-1:0] M_ONE = NUM_JULIA'(1);

   wr_state_e            state_q;
   logic [31:0]          addr_q;
   logic [31:0]          data_q;
   logic [NUM_JULIA-1:0] mask_q;
   logic [NUM_JULIA-1:0] free_q;
   logic [TO_W-1:0]      to_q;
   logic                 wr_q;
   logic [3:0]           be_q;
   logic                 err_q;
   logic                 busy_q;
   logic                 accept;

   function automatic logic onehot(
      input logic [NUM_JULIA-1:0] m
   );
      return (m != '0) && ((m & (m - M_ONE)) == '0);
   endfunction

   assign accept = (state_q == WRITE) && !avm_waitrequest;

   // writer FSM with all handshake outputs registered
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         free_q  <= '0;
         to_q    <= '0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         free_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (found) begin
                  if (onehot(mask)) begin
                     addr_q  <= sel_address;
                     data_q  <= sel_data;
                     mask_q  <= mask;
                     wr_q    <= 1'b1;
                     be_q    <= BYTE_EN_ALL;
                     busy_q  <= 1'b1;
                     state_q <= WRITE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (!avm_waitrequest) begin
                  wr_q    <= 1'b0;
                  be_q    <= '0;
                  free_q  <= mask_q;
                  state_q <= ACK;
               end
            end
            ACK: begin
               to_q    <= '0;
               state_q <= WAIT_CLR;
            end
            WAIT_CLR: begin
               if (!found) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (to_q == TO_LAST) begin
                  err_q   <= 1'b1;
                  free_q  <= mask_q;
                  to_q    <= '0;
                  state_q <= ACK;
               end else begin
                  to_q <= to_q + TO_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (frame_clear) err_q <= 1'b0;
      end
   end

   pixel_frame_counter #(
      .FRAME_PIXELS (FRAME_PIXELS),
      .CNT_W        (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .n_rst   (n_rst),
      .inc_i   (accept),
      .clr_i   (frame_clear),
      .count_o (pixel_count),
      .done_o  (frame_done)
   );

   assign free           = free_q;
   assign avm_address    = addr_q;
   assign avm_write      = wr_q;
   assign avm_writedata  = data_q;
   assign avm_byteenable = be_q;
   assign ack_error      = err_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_julia_pixel_writer.sv
// Self-checking bench for julia_pixel_writer with a
// 4-pixel frame and an 8-cycle ack timeout.
module tb_julia_pixel_writer;

   localparam int NJ = 16;
   localparam int FP = 4;
   localparam int AT = 8;
   localparam int CW = $clog2(FP + 1);

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          found = 1'b0;
   logic [31:0]   sel_address = '0;
   logic [31:0]   sel_data = '0;
   logic [NJ-1:0] mask = '0;
   logic [NJ-1:0] free;
   logic [31:0]   avm_address;
   logic          avm_write;
   logic [31:0]   avm_writedata;
   logic [3:0]    avm_byteenable;
   logic          avm_waitrequest = 1'b0;
   logic          frame_clear = 1'b0;
   logic [CW-1:0] pixel_count;
   logic          frame_done;
   logic          ack_error;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt = 0;

   julia_pixel_writer #(
      .NUM_JULIA    (NJ),
      .FRAME_PIXELS (FP),
      .ACK_TIMEOUT  (AT)
   ) dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .found           (found),
      .sel_address     (sel_address),
      .sel_data        (sel_data),
      .mask            (mask),
      .free            (free),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .frame_clear     (frame_clear),
      .pixel_count     (pixel_count),
      .frame_done      (frame_done),
      .ack_error       (ack_error),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] m;
      int          nw;
      bit          clr;
      int          ecnt;
      bit          edone;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // one full found/write/free handshake
   task automatic pixel(input logic [31:0] a, input logic [31:0] d,
                        input logic [15:0] m, input int nw,
                        input bit clr, input int ecnt,
                        input bit edone, input bit keep);
      int wc;
      int bad;
      @(negedge clk);
      found = 1'b1;
      sel_address = a;
      sel_data = d;
      mask = m;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      chk("latency", 32'(avm_write), 32'd1);
      wc = 0;
      bad = 0;
      while (avm_write === 1'b1 && wc < 50) begin
         wc++;
         if (avm_address !== a || avm_writedata !== d ||
             avm_byteenable !== 4'hF || free !== '0)
            bad++;
         avm_waitrequest = (wc <= nw);
         frame_clear = clr && (wc > nw);
         sel_address = $urandom;
         sel_data = $urandom;
         @(negedge clk);
      end
      frame_clear = 1'b0;
      chk("write_cycles", 32'(wc), 32'(nw + 1));
      chk("write_hold", 32'(bad), 32'd0);
      chk("free_pulse", 32'(free), 32'(m));
      chk("pixel_count", 32'(pixel_count), 32'(ecnt));
      chk("frame_done", 32'(frame_done), 32'(edone));
      chk("be_idle", 32'(avm_byteenable), 32'd0);
      chk("ack_error_ok", 32'(ack_error), 32'd0);
      @(negedge clk);
      chk("free_drop", 32'(free), 32'd0);
      chk("frame_done_drop", 32'(frame_done), 32'd0);
      chk("busy_wait", 32'(busy), 32'd1);
      if (!keep) begin
         found = 1'b0;
         @(negedge clk);
         chk("busy_idle", 32'(busy), 32'd0);
         chk("no_rewrite", 32'(avm_write), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int wrs;
      int ecnt;
      bit ed;
      logic [15:0] m;
      int nw;
      bit clr;

      vecs[0] = '{32'h0000_1000, 32'h00FF_00FF, 16'h0004, 0, 1'b0, 1, 1'b0};
      vecs[1] = '{32'h0000_1004, 32'h1234_5678, 16'h0004, 3, 1'b0, 2, 1'b0};
      vecs[2] = '{32'h0000_2000, 32'hDEAD_BEEF, 16'h8000, 1, 1'b0, 3, 1'b0};
      vecs[3] = '{32'h0000_2004, 32'hCAFE_F00D, 16'h0001, 0, 1'b0, 0, 1'b1};
      vecs[4] = '{32'h0000_2008, 32'h0BAD_CAFE, 16'h0100, 0, 1'b0, 1, 1'b0};
      vecs[5] = '{32'h0000_3000, 32'h5555_AAAA, 16'h0040, 2, 1'b1, 0, 1'b0};
      vecs[6] = '{32'h0000_3004, 32'hAAAA_5555, 16'h0002, 0, 1'b0, 1, 1'b0};

      #2;
      chk("rst_write", 32'(avm_write), 32'd0);
      chk("rst_free", 32'(free), 32'd0);
      chk("rst_count", 32'(pixel_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(ack_error), 32'd0);
      chk("rst_be", 32'(avm_byteenable), 32'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         pixel(vecs[i].addr, vecs[i].data, vecs[i].m, vecs[i].nw,
               vecs[i].clr, vecs[i].ecnt, vecs[i].edone, 1'b0);
         cnt = vecs[i].ecnt;
      end

      // free timeout: keep found high after the free pulse
      cnt = (cnt + 1) % FP;
      pixel(32'h0000_4000, 32'h0F0F_0F0F, 16'h0020, 0, 1'b0,
            cnt, (cnt == 0), 1'b1);
      chk("to_err_early", 32'(ack_error), 32'd0);
      g = 0;
      wrs = 0;
      while (free === '0 && g < 40) begin
         @(negedge clk);
         g++;
         if (avm_write === 1'b1) wrs++;
      end
      chk("to_gap", 32'(g), 32'(AT));
      chk("to_err", 32'(ack_error), 32'd1);
      chk("to_refree", 32'(free), 32'h0020);
      @(negedge clk);
      chk("to_refree_drop", 32'(free), 32'd0);
      found = 1'b0;
      @(negedge clk);
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_no_write", 32'(wrs + int'(avm_write)), 32'd0);
      chk("to_count", 32'(pixel_count), 32'(cnt));
      frame_clear = 1'b1;
      @(negedge clk);
      frame_clear = 1'b0;
      cnt = 0;
      chk("clr_err", 32'(ack_error), 32'd0);
      chk("clr_count", 32'(pixel_count), 32'd0);

      // non-one-hot capture
      found = 1'b1;
      mask = 16'h0006;
      sel_address = 32'h0000_5000;
      avm_waitrequest = 1'b0;
      @(negedge clk);
      found = 1'b0;
      chk("oh_err", 32'(ack_error), 32'd1);
      chk("oh_busy", 32'(busy), 32'd0);
      chk("oh_write", 32'(avm_write), 32'd0);
      @(negedge clk);
      chk("oh_write2", 32'(avm_write), 32'd0);
      frame_clear = 1'b1;
      @(negedge clk);
      frame_clear = 1'b0;
      chk("oh_clr", 32'(ack_error), 32'd0);

      // randomized handshakes against a frame-modulo model
      for (int i = 0; i < 24; i++) begin
         m = 16'd1 << $urandom_range(15, 0);
         nw = int'($urandom_range(3, 0));
         clr = ($urandom_range(7, 0) == 0);
         if (clr) begin
            ecnt = 0;
            ed = 1'b0;
         end else begin
            ecnt = (cnt + 1) % FP;
            ed = (cnt + 1 == FP);
         end
         pixel($urandom, $urandom, m, nw, clr, ecnt, ed, 1'b0);
         cnt = ecnt;
      end

      // make sure the count is non-zero before the reset test
      cnt = (cnt + 1) % FP;
      if (cnt == 0) cnt = 1;
      while (int'(pixel_count) != cnt) begin
         pixel(32'h0000_6000, 32'h1, 16'h0008, 0, 1'b0,
               (int'(pixel_count) + 1) % FP,
               (int'(pixel_count) + 1 == FP), 1'b0);
      end

      // reset while stalled in WRITE
      @(negedge clk);
      found = 1'b1;
      mask = 16'h0010;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      chk("rw_write", 32'(avm_write), 32'd1);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("rw_write_drop", 32'(avm_write), 32'd0);
      chk("rw_free", 32'(free), 32'd0);
      chk("rw_count", 32'(pixel_count), 32'd0);
      found = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      avm_waitrequest = 1'b0;
      @(negedge clk);
      chk("rw_busy", 32'(busy), 32'd0);
      chk("rw_write2", 32'(avm_write), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
